// File: rtl/adc_rec_pkg.sv
// Shared types, default widths and the channel-slice helper for the ADC
// record sequencer.
package adc_rec_pkg;

  localparam int DEF_NCH = 8;
  localparam int DEF_SW  = 12;
  localparam int DEF_AW  = 15;
  localparam int DEF_RLW = 16;
  localparam int DEF_NRW = 8;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_DELAY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } rec_state_e;

  // Bit offset of channel k inside a packed NCH*SW sample word.
  function automatic int chan_lsb(input int k, input int sw);
    return k * sw;
  endfunction

endpackage

// File: rtl/adc_record_sequencer_if.sv
// Record-memory write port bundle: the sequencer drives it, the RAM side
// consumes it.
interface adc_record_sequencer_if
  import adc_rec_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int SW  = DEF_SW,
  parameter int AW  = DEF_AW
);
  // wen qualifies waddr/wdata for exactly one cycle; there is no backpressure.
  logic                wen;
  logic [AW-1:0]       waddr;
  logic [NCH*SW-1:0]   wdata;

  modport master (output wen, output waddr, output wdata);
  modport slave  (input  wen, input  waddr, input  wdata);
endinterface

// File: rtl/adc_rec_decim.sv
// Decimation counter: keeps the first valid sample after clear, then one of
// every ratio+1 valid samples.
module adc_rec_decim (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic       clear,
  input  logic [7:0] ratio,
  output logic       keep
);

  logic [7:0] cnt_q, cnt_d;

  assign keep = valid && (cnt_q == 8'd0);

  // Count valid samples 0..ratio and wrap; clear restarts on the kept phase.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (valid) begin
      cnt_d = (cnt_q == ratio) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/adc_record_sequencer.sv
// Triggered, segmented capture of the deserialised ADC stream into record
// memory, with trigger delay, decimation, overrun protection and a
// missed-trigger counter.
module adc_record_sequencer
  import adc_rec_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int SW  = DEF_SW,
  parameter int AW  = DEF_AW,
  parameter int RLW = DEF_RLW,
  parameter int NRW = DEF_NRW
) (
  input  logic              ref_frame_clk,
  input  logic              iStateReset,
  // iSampleValid qualifies iSampleData each cycle; no backpressure upstream.
  input  logic [NCH*SW-1:0] iSampleData,
  input  logic              iSampleValid,
  input  logic              iSystemTrig,
  input  logic [RLW-1:0]    iRecLength,
  input  logic [RLW-1:0]    iTrigDelay,
  input  logic [7:0]        iDecimate,
  input  logic [NRW-1:0]    iNumRecords,
  output logic              oWEN,
  output logic [AW-1:0]     oWAddr,
  output logic [NCH*SW-1:0] oWData,
  output logic              oBusy,
  output logic              oDataReady,
  output logic              oOverrun,
  output logic [NRW-1:0]    oRecCount,
  output logic [7:0]        oMissedTrig,
  output logic [1:0]        dbg_state
);

  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

  rec_state_e          state_q, state_d;
  logic                trig_q;
  logic [RLW-1:0]      len_q, len_d;
  logic [RLW-1:0]      dly_q, dly_d;
  logic [7:0]          dec_q, dec_d;
  logic [NRW-1:0]      nrec_q, nrec_d;
  logic [RLW-1:0]      smp_cnt_q, smp_cnt_d;
  logic [RLW-1:0]      dly_cnt_q, dly_cnt_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                full_q, full_d;
  logic                wen_q, wen_d;
  logic [AW-1:0]       waddr_q, waddr_d;
  logic [NCH*SW-1:0]   wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                overrun_q, overrun_d;
  logic [NRW-1:0]      rec_cnt_q, rec_cnt_d;
  logic [7:0]          missed_q, missed_d;

  logic                trig_edge;
  logic [NRW-1:0]      nrec_eff;
  logic [NRW:0]        rec_next;
  logic                more_armed, more_cap;
  logic                rec_full;
  logic                dec_valid, dec_clear, keep;

  assign trig_edge  = iSystemTrig & ~trig_q;
  assign nrec_eff   = (iNumRecords == '0) ? NRW'(1) : iNumRecords;
  assign rec_next   = {1'b0, rec_cnt_q} + {{NRW{1'b0}}, 1'b1};
  assign more_armed = rec_next < {1'b0, nrec_eff};
  assign more_cap   = rec_next < {1'b0, nrec_q};
  assign rec_full   = (smp_cnt_q == len_q);

  // Decimator sees samples only while a record is still being filled.
  assign dec_valid = (state_q == ST_CAPTURE) && !rec_full && iSampleValid;
  assign dec_clear = (state_q == ST_ARMED) && trig_edge;

  adc_rec_decim u_decim (
    .clk   (ref_frame_clk),
    .rst   (iStateReset),
    .valid (dec_valid),
    .clear (dec_clear),
    .ratio (dec_q),
    .keep  (keep)
  );

  // Next-state and datapath: arm, delay, capture, record end, overrun.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    dly_d     = dly_q;
    dec_d     = dec_q;
    nrec_d    = nrec_q;
    smp_cnt_d = smp_cnt_q;
    dly_cnt_d = dly_cnt_q;
    addr_d    = addr_q;
    full_d    = full_q;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    rec_cnt_d = rec_cnt_q;
    missed_d  = missed_q;

    // Edges while a record is in flight are dropped but counted.
    if (trig_edge && (state_q == ST_DELAY || state_q == ST_CAPTURE) &&
        missed_q != 8'hFF) begin
      missed_d = missed_q + 8'd1;
    end

    case (state_q)
      ST_ARMED: begin
        if (trig_edge) begin
          len_d     = iRecLength;
          dly_d     = iTrigDelay;
          dec_d     = iDecimate;
          nrec_d    = nrec_eff;
          smp_cnt_d = '0;
          dly_cnt_d = '0;
          if (iRecLength == '0) begin
            // Empty record completes on the trigger edge itself.
            rec_cnt_d = rec_next[NRW-1:0];
            if (more_armed) begin
              state_d = ST_ARMED;
            end else begin
              state_d = ST_DONE;
              ready_d = 1'b1;
            end
          end else if (iTrigDelay == '0) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_DELAY;
          end
        end
      end

      ST_DELAY: begin
        if (dly_cnt_q == dly_q - RLW'(1)) begin
          state_d = ST_CAPTURE;
        end else begin
          dly_cnt_d = dly_cnt_q + RLW'(1);
        end
      end

      ST_CAPTURE: begin
        if (rec_full) begin
          rec_cnt_d = rec_next[NRW-1:0];
          if (more_cap) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_DONE;
            ready_d = 1'b1;
          end
        end else if (keep) begin
          if (full_q) begin
            // Last address already used: refuse the write and stop.
            overrun_d = 1'b1;
            ready_d   = 1'b1;
            state_d   = ST_DONE;
          end else begin
            wen_d     = 1'b1;
            waddr_d   = addr_q;
            wdata_d   = iSampleData;
            smp_cnt_d = smp_cnt_q + RLW'(1);
            if (addr_q == ADDR_MAX) full_d = 1'b1;
            else                    addr_d = addr_q + AW'(1);
          end
        end
      end

      default: begin
        state_d = ST_DONE;
      end
    endcase
  end

  // State and datapath registers; the trigger history tracks the input even
  // in reset so a level held through reset is not seen as an edge.
  always_ff @(posedge ref_frame_clk) begin
    trig_q <= iSystemTrig;
    if (iStateReset) begin
      state_q   <= ST_ARMED;
      len_q     <= '0;
      dly_q     <= '0;
      dec_q     <= '0;
      nrec_q    <= '0;
      smp_cnt_q <= '0;
      dly_cnt_q <= '0;
      addr_q    <= '0;
      full_q    <= 1'b0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      rec_cnt_q <= '0;
      missed_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      dly_q     <= dly_d;
      dec_q     <= dec_d;
      nrec_q    <= nrec_d;
      smp_cnt_q <= smp_cnt_d;
      dly_cnt_q <= dly_cnt_d;
      addr_q    <= addr_d;
      full_q    <= full_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      rec_cnt_q <= rec_cnt_d;
      missed_q  <= missed_d;
    end
  end

  assign oWEN        = wen_q;
  assign oWAddr      = waddr_q;
  assign oWData      = wdata_q;
  assign oBusy       = (state_q == ST_DELAY) || (state_q == ST_CAPTURE);
  assign oDataReady  = ready_q;
  assign oOverrun    = overrun_q;
  assign oRecCount   = rec_cnt_q;
  assign oMissedTrig = missed_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_adc_record_sequencer.sv
// Directed bench for adc_record_sequencer: writes are checked by a monitor
// against an expected queue, status outputs by cycle-exact checks.
module tb_adc_record_sequencer;
  import adc_rec_pkg::*;

  localparam int NCH = 8;
  localparam int SW  = 12;
  localparam int AW  = 4;
  localparam int RLW = 16;
  localparam int NRW = 8;
  localparam int DW  = NCH * SW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           trig = 1'b0;
  logic           valid = 1'b1;
  logic [RLW-1:0] rec_len = '0;
  logic [RLW-1:0] trig_dly = '0;
  logic [7:0]     decim = '0;
  logic [NRW-1:0] num_rec = '0;
  logic           busy, ready, overrun;
  logic [NRW-1:0] rec_cnt;
  logic [7:0]     missed;
  logic [1:0]     dbg_state;
  logic [DW-1:0]  sample_data;

  int seq = 0;
  int errors = 0;
  int checks = 0;
  logic [AW+DW-1:0] exp_q[$];

  function automatic logic [DW-1:0] ramp(input int s);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) r[chan_lsb(k, SW) +: SW] = SW'(s * 16 + k);
    return r;
  endfunction

  assign sample_data = ramp(seq);

  adc_record_sequencer_if #(.NCH(NCH), .SW(SW), .AW(AW)) wr_if ();

  adc_record_sequencer #(.NCH(NCH), .SW(SW), .AW(AW), .RLW(RLW), .NRW(NRW)) dut (
    .ref_frame_clk (clk),
    .iStateReset   (rst),
    .iSampleData   (sample_data),
    .iSampleValid  (valid),
    .iSystemTrig   (trig),
    .iRecLength    (rec_len),
    .iTrigDelay    (trig_dly),
    .iDecimate     (decim),
    .iNumRecords   (num_rec),
    .oWEN          (wr_if.wen),
    .oWAddr        (wr_if.waddr),
    .oWData        (wr_if.wdata),
    .oBusy         (busy),
    .oDataReady    (ready),
    .oOverrun      (overrun),
    .oRecCount     (rec_cnt),
    .oMissedTrig   (missed),
    .dbg_state     (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    seq++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic cfg(input int len, input int dly, input int dec, input int nrec);
    rec_len  = RLW'(len);
    trig_dly = RLW'(dly);
    decim    = 8'(dec);
    num_rec  = NRW'(nrec);
  endtask

  task automatic push(input int addr, input int s);
    exp_q.push_back({AW'(addr), ramp(s)});
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [AW+DW-1:0] exp_w;
    if (wr_if.wen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %h at %0t",
                 wr_if.waddr, wr_if.wdata, $time);
      end else begin
        exp_w = exp_q.pop_front();
        if ({wr_if.waddr, wr_if.wdata} !== exp_w) begin
          errors++;
          $display("FAIL write: got addr %0d data %h expected addr %0d data %h at %0t",
                   wr_if.waddr, wr_if.wdata, exp_w[AW+DW-1:DW], exp_w[DW-1:0], $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset state
    ticks(2);
    chk("rst_wen", int'(wr_if.wen), 0);
    chk("rst_waddr", int'(wr_if.waddr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_state", int'(dbg_state), int'(ST_ARMED));
    rst = 1'b0;
    tick();

    // 1: length 4, no delay, no decimation
    cfg(4, 0, 0, 1);
    for (int i = 0; i < 4; i++) push(i, seq + 1 + i);
    trig = 1'b1; tick(); trig = 1'b0;              // T+1
    chk("t1_state_capture", int'(dbg_state), int'(ST_CAPTURE));
    tick();                                         // T+2
    chk("t1_first_wen", int'(wr_if.wen), 1);
    chk("t1_first_addr", int'(wr_if.waddr), 0);
    ticks(3);                                       // T+5
    chk("t1_busy_t5", int'(busy), 1);
    chk("t1_ready_t5", int'(ready), 0);
    tick();                                         // T+6
    chk("t1_ready", int'(ready), 1);
    chk("t1_reccount", int'(rec_cnt), 1);
    chk("t1_busy_done", int'(busy), 0);
    chk("t1_wen_done", int'(wr_if.wen), 0);

    // 2: delay 3, decimate by 3, length 3
    do_reset();
    cfg(3, 3, 2, 1);
    push(0, seq + 4); push(1, seq + 7); push(2, seq + 10);
    trig = 1'b1; tick(); trig = 1'b0;              // T+1
    chk("t2_state_delay", int'(dbg_state), int'(ST_DELAY));
    chk("t2_busy_delay", int'(busy), 1);
    ticks(3);                                       // T+4
    chk("t2_state_capture", int'(dbg_state), int'(ST_CAPTURE));
    chk("t2_wen_t4", int'(wr_if.wen), 0);
    tick();                                         // T+5
    chk("t2_wen_t5", int'(wr_if.wen), 1);
    ticks(6);                                       // T+11
    chk("t2_last_addr", int'(wr_if.waddr), 2);
    chk("t2_reccount_t11", int'(rec_cnt), 0);
    tick();                                         // T+12
    chk("t2_reccount", int'(rec_cnt), 1);
    chk("t2_ready", int'(ready), 1);

    // 3: three contiguous records of 5
    do_reset();
    cfg(5, 0, 0, 3);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) push(5 * r + i, seq + 1 + i);
      trig = 1'b1; tick(); trig = 1'b0;            // T+1
      ticks(6);                                     // T+7
      chk("t3_reccount", int'(rec_cnt), r + 1);
      chk("t3_ready", int'(ready), (r == 2) ? 1 : 0);
      chk("t3_busy", int'(busy), 0);
      ticks(13);                                    // next edge cycle
    end

    // 4: address space overrun at AW=4
    do_reset();
    cfg(20, 0, 0, 1);
    for (int i = 0; i < 16; i++) push(i, seq + 1 + i);
    trig = 1'b1; tick(); trig = 1'b0;              // T+1
    ticks(16);                                      // T+17
    chk("t4_last_addr", int'(wr_if.waddr), 15);
    chk("t4_overrun_t17", int'(overrun), 0);
    tick();                                         // T+18
    chk("t4_overrun", int'(overrun), 1);
    chk("t4_ready", int'(ready), 1);
    chk("t4_wen", int'(wr_if.wen), 0);
    chk("t4_reccount", int'(rec_cnt), 0);
    ticks(3);

    // 5a: extra trigger edge during capture
    do_reset();
    cfg(4, 0, 0, 1);
    for (int i = 0; i < 4; i++) push(i, seq + 1 + i);
    trig = 1'b1; tick(); trig = 1'b0;              // T+1
    tick(); trig = 1'b1;                            // T+2
    tick();                                         // T+3
    chk("t5_missed", int'(missed), 1);
    trig = 1'b0;
    ticks(3);                                       // T+6
    chk("t5_ready", int'(ready), 1);
    chk("t5_missed_hold", int'(missed), 1);

    // 5b: reset mid-capture, trigger held high through reset release
    do_reset();
    cfg(10, 0, 0, 1);
    push(0, seq + 1); push(1, seq + 2);
    trig = 1'b1; tick(); trig = 1'b0;              // T+1
    tick(); trig = 1'b1;                            // T+2
    tick();                                         // T+3
    rst = 1'b1;
    tick();                                         // T+4
    chk("t5_rst_wen", int'(wr_if.wen), 0);
    chk("t5_rst_waddr", int'(wr_if.waddr), 0);
    chk("t5_rst_missed", int'(missed), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_ready", int'(ready), 0);
    rst = 1'b0;
    ticks(10);
    chk("t5_held_trig_busy", int'(busy), 0);
    chk("t5_held_trig_state", int'(dbg_state), int'(ST_ARMED));
    trig = 1'b0;
    tick();

    // 6: zero-length record
    do_reset();
    cfg(0, 0, 0, 1);
    trig = 1'b1; tick(); trig = 1'b0;              // T+1
    chk("t6_reccount", int'(rec_cnt), 1);
    chk("t6_ready", int'(ready), 1);
    chk("t6_busy", int'(busy), 0);
    ticks(3);

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
